// File: rtl/axil_regfile_pkg.sv
// rtl/axil_regfile_pkg.sv - shared response codes, FSM encodings and access-legality helper
package axil_regfile_pkg;

    localparam logic [1:0] AXI_OK     = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_ADDR = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } rd_state_t;

    // A word index is writable when it exists and is below the read-only status block
    function automatic logic is_writable(input int unsigned idx,
                                         input int unsigned num_regs,
                                         input int unsigned num_ro);
        return (idx < num_regs) && (idx < (num_regs - num_ro));
    endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// rtl/axil_regfile_if.sv - AXI4-Lite bus bundle with master/slave views
interface axil_regfile_if #(
    parameter int ADDR_WIDTH = 8
) ();
    import axil_regfile_pkg::*;

    logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr;
    logic                  s_axi_lite_awvalid;
    logic                  s_axi_lite_awready;
    logic [31:0]           s_axi_lite_wdata;
    logic [3:0]            s_axi_lite_wstrb;
    logic                  s_axi_lite_wvalid;
    logic                  s_axi_lite_wready;
    logic [1:0]            s_axi_lite_bresp;
    logic                  s_axi_lite_bvalid;
    logic                  s_axi_lite_bready;
    logic [ADDR_WIDTH-1:0] s_axi_lite_araddr;
    logic                  s_axi_lite_arvalid;
    logic                  s_axi_lite_arready;
    logic [31:0]           s_axi_lite_rdata;
    logic [1:0]            s_axi_lite_rresp;
    logic                  s_axi_lite_rvalid;
    logic                  s_axi_lite_rready;

    modport master (
        output s_axi_lite_awaddr, s_axi_lite_awvalid, s_axi_lite_wdata, s_axi_lite_wstrb,
               s_axi_lite_wvalid, s_axi_lite_bready, s_axi_lite_araddr, s_axi_lite_arvalid,
               s_axi_lite_rready,
        input  s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp, s_axi_lite_bvalid,
               s_axi_lite_arready, s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid
    );

    modport slave (
        input  s_axi_lite_awaddr, s_axi_lite_awvalid, s_axi_lite_wdata, s_axi_lite_wstrb,
               s_axi_lite_wvalid, s_axi_lite_bready, s_axi_lite_araddr, s_axi_lite_arvalid,
               s_axi_lite_rready,
        output s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp, s_axi_lite_bvalid,
               s_axi_lite_arready, s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid
    );

endinterface

// File: rtl/axil_wr_fsm.sv
// rtl/axil_wr_fsm.sv - AXI4-Lite write channel: AW/W capture, legality check, B response
module axil_wr_fsm
    import axil_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int NUM_RO     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic                  o_commit,
    output logic [ADDR_WIDTH-3:0] o_idx,
    output logic [31:0]           o_data,
    output logic [3:0]            o_strb
);

    wr_state_t             r_state;
    wr_state_t             w_next;
    logic                  w_last_hs;
    logic                  w_ok;
    logic [ADDR_WIDTH-3:0] r_idx;
    logic [31:0]           r_data;
    logic [3:0]            r_strb;
    logic [1:0]            r_bresp;
    logic                  w_unused;

    // Byte offset within the word carries no meaning for 32-bit registers
    assign w_unused = ^i_awaddr[1:0];

    // Whichever half arrived earlier comes from the capture registers, the other is live
    assign o_idx    = (r_state == W_DATA) ? r_idx  : i_awaddr[ADDR_WIDTH-1:2];
    assign o_data   = (r_state == W_ADDR) ? r_data : i_wdata;
    assign o_strb   = (r_state == W_ADDR) ? r_strb : i_wstrb;
    assign w_ok     = is_writable(32'(o_idx), NUM_REGS, NUM_RO);
    assign o_commit = w_last_hs & w_ok;
    assign o_bresp  = r_bresp;

    // Next state and handshake outputs; w_last_hs marks the edge the second half is accepted
    always_comb begin
        w_next    = r_state;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        w_last_hs = 1'b0;
        case (r_state)
            W_IDLE: begin
                o_awready = 1'b1;
                o_wready  = 1'b1;
                if (i_awvalid && i_wvalid) begin
                    w_next    = W_RESP;
                    w_last_hs = 1'b1;
                end else if (i_awvalid) begin
                    w_next = W_DATA;
                end else if (i_wvalid) begin
                    w_next = W_ADDR;
                end
            end
            W_DATA: begin
                o_wready = 1'b1;
                if (i_wvalid) begin
                    w_next    = W_RESP;
                    w_last_hs = 1'b1;
                end
            end
            W_ADDR: begin
                o_awready = 1'b1;
                if (i_awvalid) begin
                    w_next    = W_RESP;
                    w_last_hs = 1'b1;
                end
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Hold the early half of a split transfer and latch the response at commit time
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx   <= '0;
            r_data  <= '0;
            r_strb  <= '0;
            r_bresp <= AXI_OK;
        end else begin
            if (r_state == W_IDLE && i_awvalid) begin
                r_idx <= i_awaddr[ADDR_WIDTH-1:2];
            end
            if (r_state == W_IDLE && i_wvalid) begin
                r_data <= i_wdata;
                r_strb <= i_wstrb;
            end
            if (w_last_hs) begin
                r_bresp <= w_ok ? AXI_OK : AXI_SLVERR;
            end
        end
    end

endmodule

// File: rtl/axil_regfile.sv
// rtl/axil_regfile.sv - AXI4-Lite register bank with RO status slots and write pulses; AXIL_REGFILE_WSTRB_EN enables byte-lane writes
module axil_regfile
    import axil_regfile_pkg::*;
#(
    parameter int          AXI_LITE_ADDR_WIDTH = 8,
    parameter int          NUM_REGS            = 8,
    parameter int          NUM_RO              = 2,
    parameter logic [31:0] RESET_VALUE         = 32'h0
) (
    input  logic                                    s_axi_lite_aclk,
    input  logic                                    axi_resetn,
    axil_regfile_if.slave                           s_axi_lite,
    output logic [NUM_REGS*32-1:0]                  regs_out,
    output logic [NUM_REGS-1:0]                     wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] status_in
);

    localparam int NUM_RW = NUM_REGS - NUM_RO;
    localparam int IDX_W  = AXI_LITE_ADDR_WIDTH - 2;

    logic              w_commit;
    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic [31:0]       r_regs [NUM_RW];
    logic [NUM_REGS-1:0] r_wr_pulse;
    rd_state_t         r_rstate;
    rd_state_t         w_rnext;
    logic [IDX_W-1:0]  w_ridx;
    logic [31:0]       w_rdata;
    logic [1:0]        w_rresp;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic              w_unused;

    axil_wr_fsm #(
        .ADDR_WIDTH (AXI_LITE_ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .NUM_RO     (NUM_RO)
    ) u_wr_fsm (
        .i_clk     (s_axi_lite_aclk),
        .i_rst_n   (axi_resetn),
        .i_awaddr  (s_axi_lite.s_axi_lite_awaddr),
        .i_awvalid (s_axi_lite.s_axi_lite_awvalid),
        .o_awready (s_axi_lite.s_axi_lite_awready),
        .i_wdata   (s_axi_lite.s_axi_lite_wdata),
        .i_wstrb   (s_axi_lite.s_axi_lite_wstrb),
        .i_wvalid  (s_axi_lite.s_axi_lite_wvalid),
        .o_wready  (s_axi_lite.s_axi_lite_wready),
        .o_bresp   (s_axi_lite.s_axi_lite_bresp),
        .o_bvalid  (s_axi_lite.s_axi_lite_bvalid),
        .i_bready  (s_axi_lite.s_axi_lite_bready),
        .o_commit  (w_commit),
        .o_idx     (w_idx),
        .o_data    (w_data),
        .o_strb    (w_strb)
    );

`ifdef AXIL_REGFILE_WSTRB_EN
    assign w_unused = ^s_axi_lite.s_axi_lite_araddr[1:0];
`else
    assign w_unused = ^{s_axi_lite.s_axi_lite_araddr[1:0], w_strb};
`endif

    // Register array and per-register pulses update on the commit edge
    always_ff @(posedge s_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
            r_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (w_commit && (w_idx == IDX_W'(i))) begin
`ifdef AXIL_REGFILE_WSTRB_EN
                    for (int k = 0; k < 4; k++) begin
                        if (w_strb[k]) begin
                            r_regs[i][8*k +: 8] <= w_data[8*k +: 8];
                        end
                    end
`else
                    r_regs[i] <= w_data;
`endif
                end
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                r_wr_pulse[i] <= w_commit && (w_idx == IDX_W'(i));
            end
        end
    end

    assign wr_pulse = r_wr_pulse;

    // Status slots are not storage; they present zero on the flattened output
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        if (g < NUM_RW) begin : g_rw
            assign regs_out[32*g +: 32] = r_regs[g];
        end else begin : g_ro
            assign regs_out[32*g +: 32] = '0;
        end
    end

    // Read mux: storage value before any same-edge write, live status, or SLVERR
    always_comb begin
        w_ridx  = s_axi_lite.s_axi_lite_araddr[AXI_LITE_ADDR_WIDTH-1:2];
        w_rdata = '0;
        w_rresp = AXI_SLVERR;
        for (int i = 0; i < NUM_RW; i++) begin
            if (w_ridx == IDX_W'(i)) begin
                w_rdata = r_regs[i];
                w_rresp = AXI_OK;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (w_ridx == IDX_W'(NUM_RW + j)) begin
                w_rdata = status_in[32*j +: 32];
                w_rresp = AXI_OK;
            end
        end
    end

    // Read FSM next state
    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (s_axi_lite.s_axi_lite_arvalid) w_rnext = R_VALID;
            R_VALID: if (s_axi_lite.s_axi_lite_rready)  w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read state and response registers; rdata/rresp only load on AR acceptance
    always_ff @(posedge s_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= AXI_OK;
        end else begin
            r_rstate <= w_rnext;
            if (r_rstate == R_IDLE && s_axi_lite.s_axi_lite_arvalid) begin
                r_rdata <= w_rdata;
                r_rresp <= w_rresp;
            end
        end
    end

    assign s_axi_lite.s_axi_lite_arready = (r_rstate == R_IDLE);
    assign s_axi_lite.s_axi_lite_rvalid  = (r_rstate == R_VALID);
    assign s_axi_lite.s_axi_lite_rdata   = r_rdata;
    assign s_axi_lite.s_axi_lite_rresp   = r_rresp;

endmodule

// File: tb/tb_axil_regfile.sv
// tb/tb_axil_regfile.sv - scoreboard bench for axil_regfile (8 regs, 2 status slots)
module tb_axil_regfile;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] regs_out;
    logic [7:0]   wr_pulse;
    logic [63:0]  status_in;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [31:0] m_regs [8];
    logic [7:0]  pulse;

    always #5 clk = ~clk;

    axil_regfile_if #(.ADDR_WIDTH(8)) bus ();

    axil_regfile #(
        .AXI_LITE_ADDR_WIDTH (8),
        .NUM_REGS            (8),
        .NUM_RO              (2),
        .RESET_VALUE         (32'h0)
    ) dut (
        .s_axi_lite_aclk (clk),
        .axi_resetn      (rst_n),
        .s_axi_lite      (bus),
        .regs_out        (regs_out),
        .wr_pulse        (wr_pulse),
        .status_in       (status_in)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    function automatic logic [255:0] model_out();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) v[32*i +: 32] = m_regs[i];
        return v;
    endfunction

    task automatic write_both(input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] resp,
                              output logic [7:0] p);
        int n;
        exp_b.push_back(resp);
        @(posedge clk); #1;
        bus.s_axi_lite_awaddr  = addr;
        bus.s_axi_lite_awvalid = 1'b1;
        bus.s_axi_lite_wdata   = data;
        bus.s_axi_lite_wstrb   = strb;
        bus.s_axi_lite_wvalid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(bus.s_axi_lite_awready && bus.s_axi_lite_wready) && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) timeout("aw_w_ready");
        @(posedge clk); #1;
        bus.s_axi_lite_awvalid = 1'b0;
        bus.s_axi_lite_wvalid  = 1'b0;
        @(negedge clk);
        check("b_latency", bus.s_axi_lite_bvalid, 1'b1);
        p = wr_pulse;
        @(posedge clk); #1;
    endtask

    task automatic read_chk(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int n;
        exp_r.push_back({data, resp});
        @(posedge clk); #1;
        bus.s_axi_lite_araddr  = addr;
        bus.s_axi_lite_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.s_axi_lite_arready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) timeout("arready");
        check("r_not_early", bus.s_axi_lite_rvalid, 1'b0);
        @(posedge clk); #1;
        bus.s_axi_lite_arvalid = 1'b0;
        @(negedge clk);
        check("r_latency", bus.s_axi_lite_rvalid, 1'b1);
        @(posedge clk); #1;
    endtask

    // Monitor: pops expectations whenever a B or R beat is presented and accepted
    initial begin
        logic [1:0]  eb;
        logic [33:0] er;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.s_axi_lite_bvalid && bus.s_axi_lite_bready) begin
                    if (exp_b.size() == 0) begin
                        timeout("b_unexpected");
                    end else begin
                        eb = exp_b.pop_front();
                        check("bresp", bus.s_axi_lite_bresp, eb);
                    end
                end
                if (bus.s_axi_lite_rvalid && bus.s_axi_lite_rready) begin
                    if (exp_r.size() == 0) begin
                        timeout("r_unexpected");
                    end else begin
                        er = exp_r.pop_front();
                        check("rdata", bus.s_axi_lite_rdata, er[33:2]);
                        check("rresp", bus.s_axi_lite_rresp, er[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n                  = 1'b0;
        bus.s_axi_lite_awaddr  = '0;
        bus.s_axi_lite_awvalid = 1'b0;
        bus.s_axi_lite_wdata   = '0;
        bus.s_axi_lite_wstrb   = '0;
        bus.s_axi_lite_wvalid  = 1'b0;
        bus.s_axi_lite_bready  = 1'b1;
        bus.s_axi_lite_araddr  = '0;
        bus.s_axi_lite_arvalid = 1'b0;
        bus.s_axi_lite_rready  = 1'b1;
        status_in              = {32'hCAFE0007, 32'hBEEF0006};
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", bus.s_axi_lite_bvalid, 1'b0);
        check("rst_rvalid", bus.s_axi_lite_rvalid, 1'b0);
        check("rst_rdata", bus.s_axi_lite_rdata, 32'h0);
        check("rst_resp", {bus.s_axi_lite_bresp, bus.s_axi_lite_rresp}, 4'h0);
        check("rst_wr_pulse", wr_pulse, 8'h0);
        check("rst_regs", regs_out, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {bus.s_axi_lite_awready, bus.s_axi_lite_wready, bus.s_axi_lite_arready}, 3'b111);

        // Read every index after reset
        for (int i = 0; i < 8; i++) begin
            read_chk(8'(i * 4), (i == 6) ? 32'hBEEF0006 : (i == 7) ? 32'hCAFE0007 : 32'h0, 2'b00);
        end

        // Simultaneous AW/W
        write_both(8'h04, 32'hA5A51234, 4'hF, 2'b00, pulse);
        m_regs[1] = 32'hA5A51234;
        check("t2_pulse", pulse, 8'h02);
        check("t2_regs", regs_out, model_out());
        @(negedge clk);
        check("t2_pulse_clear", wr_pulse, 8'h00);
        check("t2_b_done", bus.s_axi_lite_bvalid, 1'b0);

        // W first, AW three cycles later, B stalled four cycles
        exp_b.push_back(2'b00);
        @(posedge clk); #1;
        bus.s_axi_lite_bready = 1'b0;
        bus.s_axi_lite_wdata  = 32'h5A5A0008;
        bus.s_axi_lite_wstrb  = 4'hF;
        bus.s_axi_lite_wvalid = 1'b1;
        @(negedge clk);
        check("t3_wready", bus.s_axi_lite_wready, 1'b1);
        @(posedge clk); #1;
        bus.s_axi_lite_wvalid = 1'b0;
        bus.s_axi_lite_wdata  = 32'hFFFFFFFF;
        repeat (2) begin
            @(negedge clk);
            check("t3_w_addr_state", {bus.s_axi_lite_awready, bus.s_axi_lite_wready, bus.s_axi_lite_bvalid}, 3'b100);
            check("t3_no_early_commit", regs_out, model_out());
            @(posedge clk); #1;
        end
        bus.s_axi_lite_awaddr  = 8'h08;
        bus.s_axi_lite_awvalid = 1'b1;
        @(negedge clk);
        check("t3_awready", bus.s_axi_lite_awready, 1'b1);
        @(posedge clk); #1;
        bus.s_axi_lite_awvalid = 1'b0;
        m_regs[2] = 32'h5A5A0008;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_b_hold", {bus.s_axi_lite_bvalid, bus.s_axi_lite_bresp}, 3'b100);
            check("t3_pulse", wr_pulse, (k == 0) ? 8'h04 : 8'h00);
            if (k == 0) check("t3_regs", regs_out, model_out());
            @(posedge clk); #1;
        end
        bus.s_axi_lite_bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_back_idle", {bus.s_axi_lite_awready, bus.s_axi_lite_wready, bus.s_axi_lite_bvalid}, 3'b110);

        // Illegal writes and out-of-range read
        write_both(8'h18, 32'hDEADBEEF, 4'hF, 2'b10, pulse);
        check("t4_ro_pulse", pulse, 8'h00);
        check("t4_ro_regs", regs_out, model_out());
        write_both(8'h40, 32'hDEADBEEF, 4'hF, 2'b10, pulse);
        check("t4_oor_pulse", pulse, 8'h00);
        check("t4_oor_regs", regs_out, model_out());
        read_chk(8'h40, 32'h0, 2'b10);
        read_chk(8'h1B, 32'hBEEF0006, 2'b00);

        // Byte strobes
        write_both(8'h00, 32'h11223344, 4'hF, 2'b00, pulse);
        m_regs[0] = 32'h11223344;
        write_both(8'h00, 32'hAABBCCDD, 4'b0101, 2'b00, pulse);
`ifdef AXIL_REGFILE_WSTRB_EN
        m_regs[0] = 32'h11BB33DD;
`else
        m_regs[0] = 32'hAABBCCDD;
`endif
        check("t5_pulse", pulse, 8'h01);
        check("t5_regs", regs_out, model_out());
        read_chk(8'h00, m_regs[0], 2'b00);
        write_both(8'h0C, 32'h77777777, 4'h0, 2'b00, pulse);
`ifndef AXIL_REGFILE_WSTRB_EN
        m_regs[3] = 32'h77777777;
`endif
        check("t5_zero_strb_pulse", pulse, 8'h08);
        check("t5_zero_strb_regs", regs_out, model_out());

        // Reset while W_DATA pending and R stalled
        bus.s_axi_lite_rready = 1'b0;
        @(posedge clk); #1;
        bus.s_axi_lite_araddr  = 8'h04;
        bus.s_axi_lite_arvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_lite_arvalid = 1'b0;
        bus.s_axi_lite_awaddr  = 8'h10;
        bus.s_axi_lite_awvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_lite_awvalid = 1'b0;
        @(negedge clk);
        check("t6_pre_state", {bus.s_axi_lite_rvalid, bus.s_axi_lite_awready, bus.s_axi_lite_wready}, 3'b101);
        check("t6_stalled_rdata", bus.s_axi_lite_rdata, 32'hA5A51234);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        check("t6_rst_rvalid", bus.s_axi_lite_rvalid, 1'b0);
        check("t6_rst_rdata", bus.s_axi_lite_rdata, 32'h0);
        check("t6_rst_bvalid", bus.s_axi_lite_bvalid, 1'b0);
        check("t6_rst_regs", regs_out, 256'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.s_axi_lite_rready = 1'b1;
        @(negedge clk);
        check("t6_idle_ready", {bus.s_axi_lite_awready, bus.s_axi_lite_wready, bus.s_axi_lite_arready, bus.s_axi_lite_rvalid}, 4'b1110);
        write_both(8'h10, 32'h0BADF00D, 4'hF, 2'b00, pulse);
        m_regs[4] = 32'h0BADF00D;
        check("t6_post_pulse", pulse, 8'h10);
        check("t6_post_regs", regs_out, model_out());
        read_chk(8'h10, 32'h0BADF00D, 2'b00);

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_b.size() + exp_r.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
- Parametrised AXI4-Lite slave register bank; next generation of the control-register logic inside our pixel generators.
- Adds configurable depth, read-only status registers, true SLVERR on out-of-range or illegal access, and per-register write pulses.
- Sits between the PS AXI-Lite interconnect and stream blocks (fractal core, packer), which consume its register outputs and strobes.

Parameters:
- AXI_LITE_ADDR_WIDTH, 8, byte-address width; word index = addr[AXI_LITE_ADDR_WIDTH-1:2].
- NUM_REGS, 8, total 32-bit registers; must be <= 2**(AXI_LITE_ADDR_WIDTH-2).
- NUM_RO, 2, top NUM_RO indices (NUM_REGS-NUM_RO .. NUM_REGS-1) are read-only status; 0 <= NUM_RO < NUM_REGS.
- RESET_VALUE, 32'h0, reset value of every read/write register.

Ports:
- s_axi_lite_aclk  in  1  sole clock.
- axi_resetn  in  1  asynchronous active-low reset.
- s_axi_lite_awaddr  in  AXI_LITE_ADDR_WIDTH  write address.
- s_axi_lite_awvalid  in  1 / s_axi_lite_awready  out  1  AW handshake.
- s_axi_lite_wdata  in  32 / s_axi_lite_wstrb  in  4  write data and byte strobes.
- s_axi_lite_wvalid  in  1 / s_axi_lite_wready  out  1  W handshake.
- s_axi_lite_bresp  out  2 / s_axi_lite_bvalid  out  1 / s_axi_lite_bready  in  1  B channel.
- s_axi_lite_araddr  in  AXI_LITE_ADDR_WIDTH / s_axi_lite_arvalid  in  1 / s_axi_lite_arready  out  1  AR channel.
- s_axi_lite_rdata  out  32 / s_axi_lite_rresp  out  2 / s_axi_lite_rvalid  out  1 / s_axi_lite_rready  in  1  R channel.
- regs_out  out  NUM_REGS*32  flattened register contents; reg i at [32*i+:32]; RO slots read 0.
- wr_pulse  out  NUM_REGS  one-cycle pulse on reg i when a successful write to i commits.
- status_in  in  NUM_RO*32  values returned for the RO indices; sampled at read time.

Behaviour:
- Reset (async, axi_resetn=0): R/W registers = RESET_VALUE; wr_pulse=0; bvalid=0; rvalid=0; rdata=0; bresp=rresp=OKAY; both FSMs idle. Reset mid-transaction abandons it; no partial write occurs.
- Write FSM states:
  - W_IDLE: awready=wready=1. AW only -> W_DATA; W only -> W_ADDR; both -> W_RESP, commit this edge.
  - W_DATA: wready=1, awready=0; W handshake -> W_RESP, commit.
  - W_ADDR: awready=1, wready=0; AW handshake -> W_RESP, commit.
  - W_RESP: bvalid=1; bready -> W_IDLE. bvalid and bresp hold while bready=0.
- Commit timing: register and wr_pulse update on the edge the second of AW/W is accepted. bvalid asserts the next cycle, so minimum latency is 1 cycle from the last handshake to bvalid.
- Write legality: index >= NUM_REGS or index in the RO range -> bresp=SLVERR (2'b10), no register change, no wr_pulse. Otherwise bresp=OKAY. addr[1:0] is ignored.
- Read FSM states:
  - R_IDLE: arready=1. On AR handshake, register rdata/rresp and go to R_VALID.
  - R_VALID: rvalid=1, arready=0; rready -> R_IDLE. rdata/rresp stable while stalled.
- Read latency: rvalid is high the cycle after AR acceptance.
- Read data:
  - R/W index -> register value as of the AR edge; a write committing on that same edge is NOT visible.
  - RO index -> status_in slot sampled at the AR edge.
  - Out-of-range -> rdata=0, rresp=SLVERR.
- Read and write channels are fully independent; concurrent operations never stall each other.

Optional Feature:
- AXIL_REGFILE_WSTRB_EN defined: only byte lanes with wstrb[k]=1 are updated. wstrb=0 is legal: OKAY response, no change, wr_pulse still fires.
- Undefined: wstrb is ignored; every write replaces the whole 32-bit word.

Decomposition:
- Package axil_regfile_pkg:
  - AXI_OK=2'b00, AXI_SLVERR=2'b10.
  - Write-state encodings W_IDLE/W_DATA/W_ADDR/W_RESP and read-state encodings R_IDLE/R_VALID.
  - Function is_writable(index) covering the range and RO checks.
- One sub-module, axil_wr_fsm: AW/W/B capture and legality. Outputs the captured index, data and strobe plus a commit pulse. The top level holds the register array and the read path.

Test Plan:
- Reset, then read each index 0..7 -> rdata=0 for R/W regs, status_in values for idx 6,7, rresp=OKAY, rvalid exactly 1 cycle after AR.
- AW to 0x04 with W 0xA5A5_1234 on the same cycle -> regs_out[63:32]=0xA5A51234, wr_pulse[1] high one cycle, bvalid next cycle with OKAY.
- W first, AW 3 cycles later (addr 0x08), bready held low 4 cycles -> write commits on the AW edge, bvalid held steady 4 cycles, then returns to W_IDLE.
- Write 0x18 (RO idx 6) and 0x40 (idx 16) -> SLVERR, regs_out unchanged, no wr_pulse. Read 0x40 -> rdata=0, rresp=SLVERR.
- With AXIL_REGFILE_WSTRB_EN, reg0=0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> reg0=0x11BB33DD. Without the macro -> 0xAABBCCDD.
- Assert axi_resetn low while in W_DATA and while rvalid is stalled -> outputs drop to reset values immediately, no register change. Post-reset transactions complete normally.
